instr_seq: RTL and testbench
============================

Name: instr_seq

Overview:
- Sequences one 40-bit instruction at a time through the coprocessor datapath: RX stage -> decode check -> ALU -> TX stage.
- Captures the fields from the RX stage when its valid level is seen.
- Drives the ALU ready back-pressure to the RX stage, issues a start pulse to the ALU and waits for completion under a watchdog.
- Hands the 16-bit result to the TX stage with a valid/ready handshake and keeps sticky error status.

Parameters:
- TIMEOUT_CYCLES, 64, ALU cycles allowed between alu_start and alu_done before abort (>=2).
- OP_MAX, 4'd9, highest legal ALU function code in op[3:0].

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_valid  in  1  complete instruction available from RX stage (level)
- op  in  8  opcode/flags: [3:0] function, [6:4] passed to ALU, [7] no-response flag
- a1, a2, b1, b2  in  8 each  operands from RX stage
- alu_ready  out  1  to RX stage: sequencer can accept a new instruction
- alu_start  out  1  one-cycle pulse: ALU begins on latched fields
- alu_fn  out  4  latched op[3:0]
- alu_flags  out  3  latched op[6:4]
- alu_a  out  16  {a1,a2} latched
- alu_b  out  16  {b1,b2} latched
- alu_done  in  1  ALU result valid (single-cycle pulse)
- alu_result  in  16  ALU result, sampled when alu_done=1
- tx_valid  out  1  result offered to TX stage
- tx_data  out  16  result word
- tx_ready  in  1  TX stage accepts tx_data
- clr_err  in  1  synchronous clear of sticky error bits
- status  out  8  {err_illegal, err_timeout, busy, 1'b0, instr_cnt[3:0]}

Behaviour:
- Reset values: state IDLE, alu_ready=1, alu_start=0, tx_valid=0, tx_data=0, all latched fields 0, errors 0, instr_cnt 0.
- FSM states: IDLE, DECODE, ISSUE, EXEC, RESP.
- IDLE: alu_ready=1. On rx_valid=1, latch op/a1/a2/b1/b2 and go to DECODE. alu_ready drops in the cycle after capture.
- DECODE (1 cycle): if op[3:0] > OP_MAX, set err_illegal, load tx_data=16'hDEAD, then go to RESP (or IDLE if op[7]=1). Otherwise go to ISSUE.
- ISSUE (1 cycle): alu_start=1, clear watchdog counter, then go to EXEC.
- EXEC: watchdog counter increments each cycle.
  - On alu_done=1: tx_data <= alu_result.
  - On counter == TIMEOUT_CYCLES-1 with no done: set err_timeout, tx_data <= 16'hFFFF.
  - Either event goes to RESP, or to IDLE if op[7]=1.
  - If alu_done and timeout occur in the same cycle, done wins: no error, result kept.
- RESP: tx_valid=1 with tx_data stable. On tx_ready=1, go to IDLE; tx_valid is deasserted the following cycle.
- Instruction completion: instr_cnt increments (mod 16) on every transition from EXEC or DECODE toward RESP/IDLE, including errored instructions.
- Latency: capture -> alu_start is 2 cycles; alu_done -> tx_valid is 1 cycle.
- Minimum IDLE->IDLE period is 5 cycles with alu_done on the first EXEC cycle and tx_ready held high.
- rx_valid outside IDLE is ignored; the RX stage holds its data because alu_ready=0.
- alu_done outside EXEC is ignored.
- Errors: err bits are sticky. clr_err clears them next cycle; a set event in the same cycle as clr_err wins.
- busy = (state != IDLE).
- Asynchronous reset mid-instruction aborts to IDLE immediately: no tx_valid is produced and counters are cleared.

Decomposition:
- Shared package `coproc_pkg`:
  - state enum `seq_state_t`
  - constants OP_MAX_DEFAULT, ILLEGAL_RESULT=16'hDEAD, TIMEOUT_RESULT=16'hFFFF
  - status bit index constants
- Sub-module `seq_watchdog`: loadable up-counter with clear/enable and terminal-count flag parameterised by TIMEOUT_CYCLES. Everything else stays in instr_seq.

Test Plan:
- Legal op: op=8'h02, a1/a2=8'h12/34, b1/b2=8'h00/05, ALU returns 16'h1239 three cycles after start, tx_ready=1 -> alu_start 2 cycles after capture, alu_a=16'h1234, alu_b=16'h0005, tx_data=16'h1239, instr_cnt=1, alu_ready back high.
- Illegal op: op=8'h0F -> no alu_start, err_illegal=1, tx_valid with 16'hDEAD; then clr_err -> status[7]=0.
- Timeout: TIMEOUT_CYCLES=8, alu_done never asserted -> tx_data=16'hFFFF, err_timeout=1 exactly 8 cycles after alu_start.
- Done/timeout collision: alu_done on the terminal cycle with result 16'h00AA -> tx_data=16'h00AA, err_timeout=0.
- Back-pressure and no-response: tx_ready held low 10 cycles -> tx_valid/tx_data stable and a second rx_valid is ignored; op=8'h81 -> ALU runs, no tx_valid, straight to IDLE.
- Reset mid-EXEC: assert rst_n=0 -> all outputs at reset values asynchronously, next instruction processes normally.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor instruction sequencer.
package coproc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_RESP   = 3'd4
  } seq_state_t;

  localparam logic [3:0]  OP_MAX_DEFAULT = 4'd9;
  localparam logic [15:0] ILLEGAL_RESULT = 16'hDEAD;
  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

  // Bit positions inside the status byte
  localparam int ST_ERR_ILLEGAL = 7;
  localparam int ST_ERR_TIMEOUT = 6;
  localparam int ST_BUSY        = 5;
  localparam int ST_CNT_MSB     = 3;

endpackage

// File: rtl/seq_watchdog.sv
// Loadable up-counter with clear/enable; tc flags the last allowed ALU cycle.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // clr has priority over load, load over count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_seq.sv
// Sequences one 40-bit instruction at a time: capture, decode check, ALU issue
// under a watchdog, then hand the 16-bit result to the TX stage.
module instr_seq
  import coproc_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [3:0] OP_MAX         = OP_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  op,
  input  logic [7:0]  a1,
  input  logic [7:0]  a2,
  input  logic [7:0]  b1,
  input  logic [7:0]  b2,
  output logic        alu_ready,
  output logic        alu_start,
  output logic [3:0]  alu_fn,
  output logic [2:0]  alu_flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        clr_err,
  output logic [7:0]  status,
  output logic [2:0]  dbg_state
);

  // Handshakes: rx_valid is a level consumed only in IDLE (alu_ready=1); the
  // RX stage holds its fields while alu_ready=0. tx_valid/tx_data stay frozen
  // until a cycle with tx_valid && tx_ready, which is the single transfer.

  seq_state_t  state, state_d;
  logic [7:0]  op_q;
  logic [15:0] tx_d;
  logic        capture, set_ill, set_to, tx_load, finish;
  logic        wd_clr, wd_en, wd_tc;
  logic        err_illegal, err_timeout;
  logic [3:0]  instr_cnt;

  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wd_clr),
    .en       (wd_en),
    .load     (1'b0),
    .load_val ('0),
    .tc       (wd_tc)
  );

  always_comb begin
    state_d = state;
    capture = 1'b0;
    set_ill = 1'b0;
    set_to  = 1'b0;
    tx_load = 1'b0;
    tx_d    = tx_data;
    finish  = 1'b0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          capture = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q[3:0] > OP_MAX) begin
          set_ill = 1'b1;
          tx_load = 1'b1;
          tx_d    = ILLEGAL_RESULT;
          finish  = 1'b1;
          state_d = op_q[7] ? S_IDLE : S_RESP;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wd_en = 1'b1;
        // A done landing on the terminal cycle still counts as success
        if (alu_done) begin
          tx_load = 1'b1;
          tx_d    = alu_result;
          finish  = 1'b1;
          state_d = op_q[7] ? S_IDLE : S_RESP;
        end else if (wd_tc) begin
          set_to  = 1'b1;
          tx_load = 1'b1;
          tx_d    = TIMEOUT_RESULT;
          finish  = 1'b1;
          state_d = op_q[7] ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      tx_data     <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      instr_cnt   <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        op_q  <= op;
        alu_a <= {a1, a2};
        alu_b <= {b1, b2};
      end
      if (tx_load) begin
        tx_data <= tx_d;
      end
      if (finish) begin
        instr_cnt <= instr_cnt + 4'd1;
      end
      // Set events beat a simultaneous clear
      if (set_ill)      err_illegal <= 1'b1;
      else if (clr_err) err_illegal <= 1'b0;
      if (set_to)       err_timeout <= 1'b1;
      else if (clr_err) err_timeout <= 1'b0;
    end
  end

  assign alu_ready = (state == S_IDLE);
  assign alu_start = (state == S_ISSUE);
  assign tx_valid  = (state == S_RESP);
  assign alu_fn    = op_q[3:0];
  assign alu_flags = op_q[6:4];
  assign status    = {err_illegal, err_timeout, (state != S_IDLE), 1'b0, instr_cnt};
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_seq.sv
// Bench for instr_seq: table of instructions with a reactive ALU/TX model,
// scoreboard on transferred results, plus reset and error-clear sequences.
module tb_instr_seq;
  import coproc_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  op = '0, a1 = '0, a2 = '0, b1 = '0, b2 = '0;
  logic        alu_ready, alu_start;
  logic [3:0]  alu_fn;
  logic [2:0]  alu_flags;
  logic [15:0] alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  status;
  logic [2:0]  dbg_state;

  instr_seq #(.TIMEOUT_CYCLES(T), .OP_MAX(4'd9)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .op(op),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .alu_ready(alu_ready), .alu_start(alu_start), .alu_fn(alu_fn),
    .alu_flags(alu_flags), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .clr_err(clr_err), .status(status), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the capture cycle; the DUT samples rx_valid at its end.
  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;       // alu_done this many cycles after alu_start (0 = never)
    logic [15:0] res;
    int          hold;      // cycles tx_ready stays low once tx_valid is expected
    logic        start;     // expect an alu_start
    logic        resp;      // expect a TX transfer
    logic [15:0] data;
    int          first_tx;  // cycle tx_valid is first seen (-1 = never)
    int          idle_cyc;  // cycle the FSM is back in IDLE
    logic        ill;
    logic        to;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] cnt_model = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int start_cyc = -1;
    int n_starts = 0;
    int first_seen = -1;
    int idle_seen = -1;
    logic [15:0] held = '0;
    logic [15:0] got;
    pulse_clr();
    if (v.resp) exp_q.push_back(v.data);
    @(negedge clk);
    check($sformatf("v%0d_ready_idle", idx), {31'd0, alu_ready}, 32'd1);
    rx_valid = 1'b1;
    op = v.op; a1 = v.a[15:8]; a2 = v.a[7:0]; b1 = v.b[15:8]; b2 = v.b[7:0];
    alu_done = 1'b0;
    tx_ready = (v.first_tx >= 0) ? (0 >= v.first_tx + v.hold) : 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (dbg_state == S_IDLE) begin
        idle_seen = cyc;
        break;
      end
      if (alu_start) begin
        n_starts++;
        start_cyc = cyc;
        check($sformatf("v%0d_alu_ab", idx), {alu_a, alu_b}, {v.a, v.b});
        check($sformatf("v%0d_alu_fn_flags", idx), {25'd0, alu_flags, alu_fn}, {25'd0, v.op[6:0]});
      end
      if (tx_valid) begin
        if (first_seen < 0) begin
          first_seen = cyc;
          held = tx_data;
        end else begin
          check($sformatf("v%0d_tx_stable_c%0d", idx, cyc), {16'd0, tx_data}, {16'd0, held});
        end
      end
      tx_ready = (v.first_tx >= 0) ? (cyc >= v.first_tx + v.hold) : 1'b1;
      // Noise while stalled: a new instruction and a stray done must be ignored
      if (v.hold > 0 && tx_valid && !tx_ready) begin
        rx_valid = 1'b1;
        op = 8'($urandom_range(0, 255)); a1 = 8'($urandom_range(0, 255));
        a2 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        alu_done = 1'b1;
        alu_result = 16'($urandom_range(0, 65535));
      end else begin
        rx_valid = 1'b0;
        alu_done = (v.lat > 0 && start_cyc >= 0 && cyc == start_cyc + v.lat);
        alu_result = alu_done ? v.res : 16'($urandom_range(0, 65535));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d_unexpected_tx", idx), {31'd0, tx_valid}, 32'd0);
        end else begin
          got = exp_q.pop_front();
          check($sformatf("v%0d_tx_data", idx), {16'd0, tx_data}, {16'd0, got});
        end
      end
    end
    rx_valid = 1'b0;
    alu_done = 1'b0;
    cnt_model = cnt_model + 4'd1;
    check($sformatf("v%0d_n_starts", idx), n_starts, v.start ? 1 : 0);
    if (v.start) check($sformatf("v%0d_start_lat", idx), start_cyc, 2);
    check($sformatf("v%0d_first_tx", idx), first_seen, v.first_tx);
    check($sformatf("v%0d_idle_cyc", idx), idle_seen, v.idle_cyc);
    check($sformatf("v%0d_status", idx), {24'd0, status}, {24'd0, v.ill, v.to, 2'b00, cnt_model});
    check($sformatf("v%0d_ready_tx_after", idx), {30'd0, alu_ready, tx_valid}, 32'd2);
    check($sformatf("v%0d_q_empty", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    //         op     a         b        lat res       hold st resp data      ftx idle ill to
    vecs[0] = '{8'h02, 16'h1234, 16'h0005, 3, 16'h1239, 0,  1, 1, 16'h1239,  6,  7, 0, 0};
    vecs[1] = '{8'h0F, 16'hAAAA, 16'h5555, 0, 16'h0000, 0,  0, 1, 16'hDEAD,  2,  3, 1, 0};
    vecs[2] = '{8'h03, 16'h0102, 16'h0304, 0, 16'h0000, 0,  1, 1, 16'hFFFF, 11, 12, 0, 1};
    vecs[3] = '{8'h05, 16'h0A0B, 16'h0C0D, 8, 16'h00AA, 0,  1, 1, 16'h00AA, 11, 12, 0, 0};
    vecs[4] = '{8'h01, 16'hBEEF, 16'h0011, 1, 16'h5A5A, 10, 1, 1, 16'h5A5A,  4, 15, 0, 0};
    vecs[5] = '{8'h81, 16'h1111, 16'h2222, 2, 16'h7777, 0,  1, 0, 16'h0000, -1,  5, 0, 0};
    vecs[6] = '{8'h8A, 16'h3333, 16'h4444, 0, 16'h0000, 0,  0, 0, 16'h0000, -1,  2, 1, 0};
    vecs[7] = '{8'h79, 16'hCAFE, 16'hF00D, 1, 16'h1357, 0,  1, 1, 16'h1357,  4,  5, 0, 0};
    vecs[8] = '{8'h0A, 16'h0001, 16'h0002, 0, 16'h0000, 0,  0, 1, 16'hDEAD,  2,  3, 1, 0};
    vecs[9] = '{8'h84, 16'h0003, 16'h0004, 0, 16'h0000, 0,  1, 0, 16'h0000, -1, 11, 0, 1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {7'd0, alu_ready, alu_start, tx_valid, tx_data, status},
          {7'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00});
    check("reset_fields", {5'd0, alu_flags, alu_fn, alu_a, alu_b[3:0]}, 32'd0);
    rst_n = 1'b1;

    // Two passes so instr_cnt wraps through 15 -> 0
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) run_vec(vecs[i], p * 10 + i);
    end

    // Sticky timeout from the last vector, then clear
    check("err_to_sticky", {31'd0, status[ST_ERR_TIMEOUT]}, 32'd1);
    pulse_clr();
    check("clr_err", {30'd0, status[ST_ERR_ILLEGAL], status[ST_ERR_TIMEOUT]}, 32'd0);

    // Asynchronous reset in the middle of EXEC
    begin
      int exec_seen = 0;
      @(negedge clk);
      rx_valid = 1'b1; op = 8'h03; a1 = 8'h55; a2 = 8'h66; b1 = 8'h77; b2 = 8'h88;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        rx_valid = 1'b0;
        if (dbg_state == S_EXEC) begin
          exec_seen = 1;
          break;
        end
      end
      check("reach_exec", exec_seen, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {7'd0, alu_ready, alu_start, tx_valid, tx_data, status},
            {7'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00});
      check("async_rst_fields", {alu_a, alu_b}, 32'd0);
      check("async_rst_state", {29'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_model = '0;
      run_vec(vecs[0], 99);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
